// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the program counter sequencer.
package pc_seq_pkg;

    localparam int PC_WIDTH = 6;
    localparam logic [PC_WIDTH-1:0] PC_RESET_VEC = '0;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_HALTED = 2'd2
    } pc_state_e;

endpackage

// File: rtl/reg_6bit.sv
// PC storage register: loads d on ld, async return to RESET_VEC.
module reg_6bit #(
    parameter int               WIDTH     = 6,
    parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RESET_VEC;
        end else if (ld) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch sequencer driving the PC register over a valid/ready fetch port.
// Build option: PC_WRAP_TRAP_EN halts on increment wrap instead of rolling to 0.
//
// state    | meaning
// S_IDLE   | PC parked at RESET_VEC, waiting for start
// S_FETCH  | presenting PC to memory, advancing on each handshake
// S_HALTED | stopped after halt (or trapped wrap), PC held for resume
import pc_seq_pkg::*;

module pc_sequencer #(
    parameter int               WIDTH     = PC_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(PC_RESET_VEC)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             halt,
    input  logic             br_en,
    input  logic [WIDTH-1:0] br_target,
    input  logic             fetch_ready,
    output logic             fetch_valid,
    output logic [WIDTH-1:0] fetch_addr,
    output logic             pc_ld,
    output logic [WIDTH-1:0] pc_next,
    output logic             halted,
    output logic             wrap
);

    pc_state_e state;
    logic      handshake;
    logic      do_inc;
    logic      trap;

    assign fetch_valid = (state == S_FETCH);
    assign halted      = (state == S_HALTED);
    assign handshake   = fetch_valid & fetch_ready;
    // halt also retires the fetch by incrementing, so it counts as an increment
    assign do_inc      = handshake & (halt | ~br_en);
    assign wrap        = do_inc & (&fetch_addr);

`ifdef PC_WRAP_TRAP_EN
    assign trap = wrap;
`else
    assign trap = 1'b0;
`endif

    always_comb begin
        pc_ld   = 1'b0;
        pc_next = (state == S_IDLE) ? RESET_VEC : fetch_addr;
        if (handshake && !trap) begin
            pc_ld   = 1'b1;
            pc_next = do_inc ? fetch_addr + WIDTH'(1) : br_target;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE:   if (start) state <= S_FETCH;
                S_FETCH:  if (handshake && (halt || trap)) state <= S_HALTED;
                S_HALTED: if (start) state <= S_FETCH;
                default:  state <= S_IDLE;
            endcase
        end
    end

    reg_6bit #(
        .WIDTH     (WIDTH),
        .RESET_VEC (RESET_VEC)
    ) u_pc (
        .clk   (clk),
        .rst_n (rst_n),
        .ld    (pc_ld),
        .d     (pc_next),
        .q     (fetch_addr)
    );

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: stimulus queues expected handshakes,
// a monitor pops and compares on every accepted fetch.
module tb_pc_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, halt, br_en, fetch_ready;
    logic [5:0] br_target;
    logic       fetch_valid, pc_ld, halted, wrap;
    logic [5:0] fetch_addr, pc_next;

    typedef struct {
        logic [5:0] addr;
        logic       ld;
        logic [5:0] next;
        logic       wrap;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .halt        (halt),
        .br_en       (br_en),
        .br_target   (br_target),
        .fetch_ready (fetch_ready),
        .fetch_valid (fetch_valid),
        .fetch_addr  (fetch_addr),
        .pc_ld       (pc_ld),
        .pc_next     (pc_next),
        .halted      (halted),
        .wrap        (wrap)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic push(input int a, input int ld, input int nx, input int w);
        exp_t e;
        e.addr = 6'(a);
        e.ld   = 1'(ld);
        e.next = 6'(nx);
        e.wrap = 1'(w);
        exp_q.push_back(e);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (fetch_valid && fetch_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_handshake_addr", int'(fetch_addr), -1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("hs_fetch_addr", int'(fetch_addr), int'(e.addr));
                        chk("hs_pc_ld", int'(pc_ld), int'(e.ld));
                        chk("hs_pc_next", int'(pc_next), int'(e.next));
                        chk("hs_wrap", int'(wrap), int'(e.wrap));
                    end
                end else begin
                    chk("idle_pc_ld", int'(pc_ld), 0);
                    chk("idle_wrap", int'(wrap), 0);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; halt = 1'b0; br_en = 1'b0;
        br_target = '0; fetch_ready = 1'b0;
        #12;
        chk("rst_fetch_valid", int'(fetch_valid), 0);
        chk("rst_fetch_addr", int'(fetch_addr), 0);
        chk("rst_pc_ld", int'(pc_ld), 0);
        chk("rst_pc_next", int'(pc_next), 0);
        chk("rst_halted", int'(halted), 0);
        chk("rst_wrap", int'(wrap), 0);
        rst_n = 1'b1;
        cyc(1);
        chk("idle_no_valid", int'(fetch_valid), 0);

        // start and stream 0..4
        for (int i = 0; i < 5; i++) push(i, 1, i + 1, 0);
        start = 1'b1; fetch_ready = 1'b1;
        cyc(1);
        start = 1'b0;
        chk("fetch_valid_after_start", int'(fetch_valid), 1);
        cyc(5);

        // stall at PC=5, halt/br_en must be ignored without a handshake
        fetch_ready = 1'b0; halt = 1'b1; br_en = 1'b1; br_target = 6'd33;
        for (int i = 0; i < 3; i++) begin
            chk("stall_addr", int'(fetch_addr), 5);
            chk("stall_valid", int'(fetch_valid), 1);
            cyc(1);
        end
        chk("stall_not_halted", int'(halted), 0);
        halt = 1'b0; br_en = 1'b0;
        for (int i = 5; i < 10; i++) push(i, 1, i + 1, 0);
        fetch_ready = 1'b1;
        cyc(1);
        chk("after_stall_addr", int'(fetch_addr), 6);
        cyc(4);

        // branches at PC=10 to 40, then to 0 (no wrap)
        br_en = 1'b1; br_target = 6'd40; push(10, 1, 40, 0);
        cyc(1);
        br_en = 1'b0; push(40, 1, 41, 0);
        chk("branch_addr", int'(fetch_addr), 40);
        cyc(1);
        br_en = 1'b1; br_target = 6'd0; push(41, 1, 0, 0);
        cyc(1);
        chk("branch_zero_addr", int'(fetch_addr), 0);

        // halt beats branch at PC=7
        br_target = 6'd7; push(0, 1, 7, 0);
        cyc(1);
        halt = 1'b1; br_target = 6'd20; push(7, 1, 8, 0);
        cyc(1);
        halt = 1'b0; br_en = 1'b0;
        chk("halt_halted", int'(halted), 1);
        chk("halt_pc", int'(fetch_addr), 8);
        chk("halt_valid", int'(fetch_valid), 0);
        cyc(1);
        chk("halt_hold_pc", int'(fetch_addr), 8);

        // resume from 8 and run to 12
        start = 1'b1; fetch_ready = 1'b0;
        cyc(1);
        start = 1'b0;
        chk("resume_valid", int'(fetch_valid), 1);
        chk("resume_addr", int'(fetch_addr), 8);
        chk("resume_halted", int'(halted), 0);
        for (int i = 8; i < 12; i++) push(i, 1, i + 1, 0);
        fetch_ready = 1'b1;
        cyc(4);
        fetch_ready = 1'b0;
        chk("pre_reset_addr", int'(fetch_addr), 12);

        // async reset mid-cycle
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", int'(fetch_valid), 0);
        chk("async_rst_addr", int'(fetch_addr), 0);
        rst_n = 1'b1;
        cyc(2);
        chk("post_rst_idle_valid", int'(fetch_valid), 0);
        chk("post_rst_idle_addr", int'(fetch_addr), 0);

        // run to 63 and increment across the top
        push(0, 1, 60, 0);
        start = 1'b1; fetch_ready = 1'b1;
        cyc(1);
        start = 1'b0; br_en = 1'b1; br_target = 6'd60;
        cyc(1);
        br_en = 1'b0;
        for (int i = 60; i < 63; i++) push(i, 1, i + 1, 0);
        cyc(3);
        chk("at_top_addr", int'(fetch_addr), 63);
`ifdef PC_WRAP_TRAP_EN
        push(63, 0, 63, 1);
        cyc(1);
        fetch_ready = 1'b0;
        chk("trap_halted", int'(halted), 1);
        chk("trap_pc", int'(fetch_addr), 63);
        chk("trap_wrap_low", int'(wrap), 0);
`else
        push(63, 1, 0, 1);
        cyc(1);
        fetch_ready = 1'b0;
        chk("wrap_addr", int'(fetch_addr), 0);
        chk("wrap_still_fetch", int'(fetch_valid), 1);
        chk("wrap_one_cycle", int'(wrap), 0);
        chk("wrap_not_halted", int'(halted), 0);
`endif
        cyc(2);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Controller that sequences the team's 6-bit program counter register (reg_6bit) for the Small Program Counter design on PYNQ-Z1. Drives the register's load strobe and load value. Issues one fetch address per cycle over a valid/ready handshake to instruction memory, and advances by increment or branch. Sits between the top-level run/halt controls and the instruction memory port.

Parameters:
WIDTH, 6, PC width in bits; must equal reg_6bit width.
RESET_VEC, 6'd0, PC value loaded at reset and on IDLE entry.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  level; IDLE/HALTED -> FETCH
halt  input  1  level; sampled only on a fetch handshake cycle
br_en  input  1  take branch on current handshake
br_target  input  WIDTH  branch destination PC
fetch_ready  input  1  memory accepts fetch_addr this cycle
fetch_valid  output  1  fetch_addr is valid
fetch_addr  output  WIDTH  current PC (register output)
pc_ld  output  1  load strobe driven to the PC register
pc_next  output  WIDTH  load value driven to the PC register
halted  output  1  high while in HALTED
wrap  output  1  one-cycle pulse when increment takes PC from all-ones to 0

Behaviour:
- Reset (rst_n=0, async): state=IDLE, PC=RESET_VEC, fetch_valid=0, pc_ld=0, halted=0, wrap=0, pc_next=RESET_VEC.
- States: IDLE, FETCH, HALTED; 2-bit encoding.
- IDLE: fetch_valid=0; PC held at RESET_VEC. start=1 -> FETCH on next edge.
- FETCH: fetch_valid=1 combinationally from state; fetch_addr=PC.
  - No handshake (fetch_ready=0): PC, fetch_addr and fetch_valid stable; halt/br_en ignored.
  - Handshake (fetch_valid & fetch_ready), priority halt > br_en > increment:
    - halt=1 -> HALTED; pc_ld=1, pc_next=PC+1. The accepted fetch is retired; resume address is the next PC.
    - br_en=1 -> pc_ld=1, pc_next=br_target; stay FETCH.
    - else -> pc_ld=1, pc_next=PC+1 (mod 2^WIDTH); stay FETCH.
  - Back-to-back handshakes give one address per cycle; the new PC is visible on fetch_addr the cycle after pc_ld.
- HALTED: halted=1, fetch_valid=0, PC held. start=1 -> FETCH with PC unchanged. No return to IDLE except via reset.
- pc_ld is combinational and asserted only in the handshake cycle. The PC register captures pc_next on the same rising edge (0-cycle control latency, 1-cycle address latency).
- Wrap-around:
  - Increment from 2^WIDTH-1 -> 0, with wrap pulsed high for exactly the handshake cycle.
  - A branch to 0 does not assert wrap.
- Simultaneous events:
  - start in FETCH is ignored.
  - halt+br_en on a handshake -> halt wins; branch is discarded.
- Reset mid-operation: async return to IDLE/RESET_VEC; fetch_valid drops immediately, without waiting for a handshake.

Optional Feature:
PC_WRAP_TRAP_EN:
- Defined: an increment that would wrap instead loads PC=2^WIDTH-1 (pc_ld=0) and enters HALTED; wrap still pulses.
- Undefined: PC wraps to 0 and execution continues in FETCH.

Decomposition:
- Package pc_seq_pkg holds the state enum (S_IDLE=2'd0, S_FETCH=2'd1, S_HALTED=2'd2), the default WIDTH, and RESET_VEC constants.
- One sub-module: reg_6bit instantiated as the PC storage, driven by clk, pc_ld, pc_next, with output fetch_addr.
- The FSM and next-PC mux stay in pc_sequencer.

Test Plan:
- Reset, then start=1 with fetch_ready=1 held: fetch_addr sequence 0,1,2,3. pc_ld high each FETCH cycle. fetch_valid=1 from the cycle after start.
- fetch_ready=0 for 3 cycles at PC=5: fetch_addr stays 5 and fetch_valid stays 1. On ready=1, next fetch_addr=6.
- At PC=10, handshake with br_en=1, br_target=40: next fetch_addr=40, wrap=0. Repeat with br_target=0: wrap=0.
- Run to PC=63, handshake:
  - Macro undefined: fetch_addr=0, wrap=1 for one cycle, still FETCH.
  - PC_WRAP_TRAP_EN defined: halted=1, PC=63.
- At PC=7, handshake with halt=1 and br_en=1, br_target=20: halted=1, PC=8. Then start=1: fetch_addr=8 with fetch_valid=1.
- In FETCH at PC=12, drop rst_n mid-cycle: fetch_valid=0 and PC=0 immediately, without waiting for a clock. After release, state is IDLE until start.
